// File: rtl/math_adder_pkg.sv
// Shared helpers for the pipelined N-bit adder: chunk width and flat stage-payload width.
// Payload width grows by one bit when MATH_ADDER_PIPE_OVERFLOW_EN is defined (signed overflow flag).
package math_adder_pkg;

  localparam int DEF_N      = 32;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(input int n, input int stages);
    return (stages > 0) ? n / stages : 0;
  endfunction

  // valid + carry (+ ovf) + sum + a + b
  function automatic int pay_w(input int n);
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    return 3 * n + 3;
`else
    return 3 * n + 2;
`endif
  endfunction

endpackage

// File: rtl/math_adder_full_adder.sv
// Single-bit full adder cell used to build each stage's carry chain.
module math_adder_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/math_adder_pipe_stage.sv
// One pipeline stage: resolves chunk K of the sum and registers the full payload, holding on stall.
// With MATH_ADDER_PIPE_OVERFLOW_EN defined the stage also registers its chunk's signed-overflow flag.
module math_adder_pipe_stage
  import math_adder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = chunk_w(DEF_N, DEF_STAGES),
  parameter int K = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  adv_i,
  input  logic [pay_w(N)-1:0]   pay_i,
  output logic [pay_w(N)-1:0]   pay_o
);

  typedef struct packed {
    logic         valid;
    logic         carry;
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    logic         ovf;
`endif
    logic [N-1:0] sum;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pay_t;

  localparam int LO = K * W;

  pay_t         in_s;
  pay_t         res_s;
  pay_t         pay_d;
  pay_t         pay_q;
  logic [W:0]   c;
  logic [W-1:0] s;

  assign in_s = pay_i;
  assign c[0] = in_s.carry;

  for (genvar i = 0; i < W; i++) begin : g_fa
    math_adder_full_adder u_fa (
      .a_i (in_s.a[LO+i]),
      .b_i (in_s.b[LO+i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  // Low chunks already resolved and high operand chunks ride along untouched.
  always_comb begin
    res_s                = in_s;
    res_s.sum[LO +: W]   = s;
    res_s.carry          = c[W];
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    res_s.ovf            = c[W] ^ c[W-1];
`endif
  end

  // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    pay_d = pay_q;
    if (adv_i) begin
      pay_d.valid = in_s.valid;
      // Bubbles advance only the valid bit; data keeps its last value.
      if (in_s.valid) begin
        pay_d = res_s;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the whole payload is cleared so the
  // registered outputs of the last stage come out of reset at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pay_q <= '0;
    end else begin
      pay_q <= pay_d;
    end
  end

  assign pay_o = pay_q;

endmodule

// File: rtl/math_adder_pipelined_nbit.sv
// Pipelined N-bit ripple-carry adder: STAGES chunks, one per cycle, valid/ready with global stall.
// Define MATH_ADDER_PIPE_OVERFLOW_EN to add the o_ovf signed-overflow output.
module math_adder_pipelined_nbit
  import math_adder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int STAGES = DEF_STAGES
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_sum,
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
  output logic         o_ovf,
`endif
  output logic         o_carry
);

  localparam int W  = chunk_w(N, STAGES);
  localparam int PW = pay_w(N);

  if (STAGES < 1) begin : g_bad_stages
    $error("math_adder_pipelined_nbit: STAGES must be at least 1");
  end else if (N % STAGES != 0) begin : g_bad_split
    $error("math_adder_pipelined_nbit: N must be a multiple of STAGES");
  end

  typedef struct packed {
    logic         valid;
    logic         carry;
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    logic         ovf;
`endif
    logic [N-1:0] sum;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pay_t;

  logic [PW-1:0] pipe_w [STAGES+1];
  pay_t          head_s;
  pay_t          tail_s;
  logic          adv;
  logic          unused_ok;

  always_comb begin
    head_s       = '0;
    head_s.valid = i_valid;
    head_s.carry = i_c;
    head_s.a     = i_a;
    head_s.b     = i_b;
  end

  assign pipe_w[0] = head_s;
  assign tail_s    = pipe_w[STAGES];

  // Whole pipe moves together: it advances whenever the output slot is empty or being drained.
  assign adv     = !tail_s.valid || i_ready;
  assign o_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    math_adder_pipe_stage #(
      .N (N),
      .W (W),
      .K (k)
    ) u_stage (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .adv_i (adv),
      .pay_i (pipe_w[k]),
      .pay_o (pipe_w[k+1])
    );
  end

  assign o_valid = tail_s.valid;
  assign o_sum   = tail_s.sum;
  assign o_carry = tail_s.carry;
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
  assign o_ovf   = tail_s.ovf;
`endif

  // Operand copies in the last stage have no consumer.
  assign unused_ok = ^{tail_s.a, tail_s.b};

endmodule

// File: tb/tb_math_adder_pipelined_nbit.sv
// Directed self-checking bench: N=8/STAGES=2 main instance plus N=32 instances at STAGES=1 and 8.
module tb_math_adder_pipelined_nbit;

  localparam int N      = 8;
  localparam int STAGES = 2;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         i_c;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_sum;
  logic         o_carry;

  logic        v32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        c32;
  logic        d1_ready, d1_valid, d1_carry;
  logic [31:0] d1_sum;
  logic        d8_ready, d8_valid, d8_carry;
  logic [31:0] d8_sum;
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
  logic        o_ovf, d1_ovf, d8_ovf;
`endif

  logic [N:0] exp_q [$];
  int         tests;
  int         fails;
  int         got;

  always #5 i_clk = ~i_clk;

  math_adder_pipelined_nbit #(.N(N), .STAGES(STAGES)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    .o_ovf   (o_ovf),
`endif
    .o_carry (o_carry)
  );

  math_adder_pipelined_nbit #(.N(32), .STAGES(1)) dut32_s1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (v32),
    .o_ready (d1_ready),
    .i_a     (a32),
    .i_b     (b32),
    .i_c     (c32),
    .o_valid (d1_valid),
    .i_ready (1'b1),
    .o_sum   (d1_sum),
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    .o_ovf   (d1_ovf),
`endif
    .o_carry (d1_carry)
  );

  math_adder_pipelined_nbit #(.N(32), .STAGES(8)) dut32_s8 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (v32),
    .o_ready (d8_ready),
    .i_a     (a32),
    .i_b     (b32),
    .i_c     (c32),
    .o_valid (d8_valid),
    .i_ready (1'b1),
    .o_sum   (d8_sum),
`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    .o_ovf   (d8_ovf),
`endif
    .o_carry (d8_carry)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    i_valid = v;
    i_a     = a;
    i_b     = b;
    i_c     = c;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard step: retire a completing result, record an accepted input, then clock once.
  task automatic tick();
    logic [N:0] e;
    #1;
    if (o_valid && i_ready) begin
      got++;
      if (exp_q.size() == 0) begin
        check("sb spurious", 64'(o_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb result", 64'({o_carry, o_sum}), 64'(e));
      end
    end
    if (i_valid && o_ready) begin
      exp_q.push_back({1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c});
    end
    cycle();
  endtask

  initial begin
    int first;
    int last;
    int nvalid;
    tests   = 0;
    fails   = 0;
    got     = 0;
    i_rst   = 1'b1;
    i_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    v32 = 1'b0;
    a32 = '0;
    b32 = '0;
    c32 = 1'b0;
    repeat (2) cycle();

    // Reset state
    check("rst o_valid", 64'(o_valid), 64'd0);
    check("rst o_sum", 64'(o_sum), 64'd0);
    check("rst o_carry", 64'(o_carry), 64'd0);
    check("rst o_ready", 64'(o_ready), 64'd1);
    check("rst s1 valid", 64'(d1_valid), 64'd0);
    check("rst s8 valid", 64'(d8_valid), 64'd0);
    i_rst = 1'b0;
    cycle();

    // Carry crossing the chunk boundary: 0xFF + 0x01
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    check("t1 latency", 64'(o_valid), 64'd0);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("t1 valid", 64'(o_valid), 64'd1);
    check("t1 sum", 64'(o_sum), 64'h00);
    check("t1 carry", 64'(o_carry), 64'd1);
    tick();
    check("t1 bubble", 64'(o_valid), 64'd0);
    check("t1 hold sum", 64'(o_sum), 64'h00);

    // 16 back-to-back random vectors at full rate
    got    = 0;
    first  = -1;
    last   = -1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) drive(1'b1, N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
      else        drive(1'b0, '0, '0, 1'b0);
      tick();
      if (o_valid) begin
        if (first < 0) first = i;
        last = i;
        nvalid++;
      end
    end
    check("t2 results", 64'(got), 64'd16);
    check("t2 valid cycles", 64'(nvalid), 64'd16);
    check("t2 consecutive", 64'(last - first + 1), 64'd16);

    // Stall with a full pipe
    got = 0;
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    tick();
    drive(1'b1, 8'h80, 8'h80, 1'b1);
    tick();
    i_ready = 1'b0;
    drive(1'b1, 8'h0F, 8'hF1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3 o_ready", 64'(o_ready), 64'd0);
      check("t3 o_valid", 64'(o_valid), 64'd1);
      check("t3 stall sum", 64'({o_carry, o_sum}), 64'h046);
    end
    i_ready = 1'b1;
    tick();
    drive(1'b1, 8'hAA, 8'h55, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("t3 results", 64'(got), 64'd4);
    check("t3 queue empty", 64'(exp_q.size()), 64'd0);

    // Reset with two vectors in flight
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    tick();
    drive(1'b1, 8'h33, 8'h44, 1'b1);
    tick();
    check("t4 pre-rst valid", 64'(o_valid), 64'd1);
    i_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    exp_q.delete();
    cycle();
    check("t4 o_valid", 64'(o_valid), 64'd0);
    check("t4 o_sum", 64'(o_sum), 64'd0);
    check("t4 o_carry", 64'(o_carry), 64'd0);
    i_rst   = 1'b0;
    i_ready = 1'b0;
    #1;
    check("t4 o_ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4 no result", 64'(o_valid), 64'd0);
    end

`ifdef MATH_ADDER_PIPE_OVERFLOW_EN
    // Signed overflow flag
    drive(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("t5 sum 7f+1", 64'(o_sum), 64'h80);
    check("t5 ovf 7f+1", 64'(o_ovf), 64'd1);
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("t5 ovf ff+1", 64'(o_ovf), 64'd0);
    drive(1'b1, 8'h80, 8'h80, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("t5 ovf 80+80", 64'(o_ovf), 64'd1);
    tick();
`endif

    // N=32 full-carry propagation at STAGES=1 and STAGES=8
    v32 = 1'b1;
    a32 = 32'hFFFF_FFFF;
    b32 = 32'h0000_0000;
    c32 = 1'b1;
    cycle();
    check("t6 s1 valid", 64'(d1_valid), 64'd1);
    check("t6 s1 sum", 64'(d1_sum), 64'h0);
    check("t6 s1 carry", 64'(d1_carry), 64'd1);
    check("t6 s8 early", 64'(d8_valid), 64'd0);
    a32 = 32'h1234_5678;
    b32 = 32'h9ABC_DEF0;
    c32 = 1'b1;
    cycle();
    check("t6 s1 sum2", 64'({d1_carry, d1_sum}), 64'h0_ACF1_3569);
    check("t6 s8 early", 64'(d8_valid), 64'd0);
    v32 = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      cycle();
      check("t6 s8 latency", 64'(d8_valid), 64'd0);
    end
    cycle();
    check("t6 s8 valid", 64'(d8_valid), 64'd1);
    check("t6 s8 sum", 64'({d8_carry, d8_sum}), 64'h1_0000_0000);
    cycle();
    check("t6 s8 sum2", 64'({d8_carry, d8_sum}), 64'h0_ACF1_3569);
    check("t6 s1 idle", 64'(d1_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
